// File: rtl/iob_merge_rr.sv
// -----------------------------------------------------------------------------
// iob_merge_rr
//   N-master to 1-slave merge for the iob native bus (inverse of iob_split).
//   A round-robin arbiter grants one requesting master at a time, captures its
//   request into registers and presents it on the slave port. The slave
//   response is routed back to the granted master only. One transaction is in
//   flight at a time, and every transaction is followed by at least one IDLE
//   cycle.
//
// Parameters
//   N_MASTERS  number of master ports (>=1)
//   ADDR_W     address width
//   DATA_W     data width; wstrb is DATA_W/8 bits
//   TIMEOUT    slave-response watchdog limit in cycles (MERGE_TIMEOUT_EN only)
//
// Ports  (REQ_W = 1+ADDR_W+DATA_W+DATA_W/8, fields MSB->LSB {valid,address,wdata,wstrb};
//         RESP_W = DATA_W+1, fields {rdata,ready}; master i occupies slice i)
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-low reset (held in reset while 0)
//   m_req        in   N_MASTERS*REQ_W   master requests
//   m_resp       out  N_MASTERS*RESP_W  master responses
//   s_req        out  REQ_W             request to the shared slave
//   s_resp       in   RESP_W            response from the shared slave
//   timeout_err  out  1-cycle pulse when the watchdog aborts a transaction
//
// Build option
//   MERGE_TIMEOUT_EN  when defined, a watchdog aborts a BUSY transaction after
//                     TIMEOUT cycles without slave ready, answering the granted
//                     master with all-ones rdata and pulsing timeout_err. When
//                     undefined, BUSY waits indefinitely and timeout_err is 0.
// -----------------------------------------------------------------------------
module iob_merge_rr #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 1024
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic [N_MASTERS*(1+ADDR_W+DATA_W+DATA_W/8)-1:0]    m_req,
  output logic [N_MASTERS*(DATA_W+1)-1:0]                    m_resp,
  output logic [ADDR_W+DATA_W+DATA_W/8:0]                    s_req,
  input  logic [DATA_W:0]                                    s_resp,
  output logic                                               timeout_err
);

  localparam int STRB_W = DATA_W / 8;
  localparam int REQ_W  = 1 + ADDR_W + DATA_W + STRB_W;
  localparam int RESP_W = DATA_W + 1;
  localparam int IDX_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  // One extra bit so index sums can exceed N_MASTERS before wrapping.
  localparam logic [IDX_W:0] SUM_N = (IDX_W+1)'(N_MASTERS);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Master request unpacking
  // ---------------------------------------------------------------------------
  logic [N_MASTERS-1:0] m_valid;
  logic [ADDR_W-1:0]    m_addr  [N_MASTERS];
  logic [DATA_W-1:0]    m_wdata [N_MASTERS];
  logic [STRB_W-1:0]    m_wstrb [N_MASTERS];

  genvar gi;
  generate
    for (gi = 0; gi < N_MASTERS; gi++) begin : g_unpack
      assign m_valid[gi] = m_req[gi*REQ_W + REQ_W - 1];
      assign m_addr[gi]  = m_req[gi*REQ_W + DATA_W + STRB_W +: ADDR_W];
      assign m_wdata[gi] = m_req[gi*REQ_W + STRB_W +: DATA_W];
      assign m_wstrb[gi] = m_req[gi*REQ_W +: STRB_W];
    end
  endgenerate

  logic              s_ready;
  logic [DATA_W-1:0] s_rdata;
  assign s_ready = s_resp[0];
  assign s_rdata = s_resp[DATA_W:1];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  ptr_reg, ptr_next;
  logic [IDX_W-1:0]  grant_reg, grant_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [STRB_W-1:0] wstrb_reg, wstrb_next;

`ifdef MERGE_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
`else
  // TIMEOUT only matters with the watchdog built in.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  // ---------------------------------------------------------------------------
  // Round-robin pick: rotate the valid vector so bit k is master (ptr+k) mod N,
  // take the lowest set bit, then rotate the offset back to an index.
  // ---------------------------------------------------------------------------
  logic [N_MASTERS-1:0] valid_rot;
  logic [IDX_W-1:0]     pick_off;
  logic [IDX_W:0]       pick_sum;
  logic [IDX_W-1:0]     pick_idx;

  always_comb begin
    valid_rot = N_MASTERS'({m_valid, m_valid} >> ptr_reg);
    pick_off  = '0;
    // Descending scan so the smallest offset is the last (winning) write.
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      if (valid_rot[k]) begin
        pick_off = IDX_W'(k);
      end
    end
    pick_sum = {1'b0, ptr_reg} + {1'b0, pick_off};
    if (pick_sum >= SUM_N) begin
      pick_sum = pick_sum - SUM_N;
    end
    pick_idx = pick_sum[IDX_W-1:0];
  end

  // Pointer value after a completion: the master just served becomes lowest
  // priority for the next round.
  logic [IDX_W:0]   inc_sum;
  logic [IDX_W-1:0] grant_inc;

  always_comb begin
    inc_sum = {1'b0, grant_reg} + (IDX_W+1)'(1);
    if (inc_sum >= SUM_N) begin
      inc_sum = inc_sum - SUM_N;
    end
    grant_inc = inc_sum[IDX_W-1:0];
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and response generation
  // ---------------------------------------------------------------------------
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              timeout_hit;

  always_comb begin
    state_next  = state_reg;
    ptr_next    = ptr_reg;
    grant_next  = grant_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    wstrb_next  = wstrb_reg;
    resp_valid  = 1'b0;
    resp_data   = '0;
    timeout_hit = 1'b0;
`ifdef MERGE_TIMEOUT_EN
    cnt_next    = cnt_reg;
`endif

    case (state_reg)
      IDLE: begin
        // Any s_ready seen here is stale and deliberately ignored.
        if (|m_valid) begin
          grant_next = pick_idx;
          addr_next  = m_addr[pick_idx];
          wdata_next = m_wdata[pick_idx];
          wstrb_next = m_wstrb[pick_idx];
          state_next = BUSY;
`ifdef MERGE_TIMEOUT_EN
          cnt_next   = '0;
`endif
        end
      end

      BUSY: begin
        // A real slave response always beats a watchdog abort in the same cycle.
        if (s_ready) begin
          resp_valid = 1'b1;
          resp_data  = s_rdata;
          ptr_next   = grant_inc;
          state_next = IDLE;
        end
`ifdef MERGE_TIMEOUT_EN
        else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
          resp_valid  = 1'b1;
          resp_data   = '1;
          timeout_hit = 1'b1;
          ptr_next    = grant_inc;
          state_next  = IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
`endif
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers (asynchronous active-low reset drops any in-flight transaction)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      grant_reg <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      wstrb_reg <= '0;
`ifdef MERGE_TIMEOUT_EN
      cnt_reg   <= '0;
`endif
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      grant_reg <= grant_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      wstrb_reg <= wstrb_next;
`ifdef MERGE_TIMEOUT_EN
      cnt_reg   <= cnt_next;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // s_valid comes straight from the state register so reset clears it at once.
  assign s_req = {(state_reg == BUSY), addr_reg, wdata_reg, wstrb_reg};

  generate
    for (gi = 0; gi < N_MASTERS; gi++) begin : g_resp
      assign m_resp[gi*RESP_W +: RESP_W] =
        (resp_valid && (grant_reg == IDX_W'(gi))) ? {resp_data, 1'b1} : '0;
    end
  endgenerate

  assign timeout_err = timeout_hit;

endmodule
